// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite constants and the line-writer state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axi_lite_pkg;

   // Write/read response codes
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] EXOKAY = 2'b01;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;

   // Unprivileged, secure, data access
   localparam logic [2:0] AXI_PROT = 3'b000;

   // Line writer control states
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ADDR_DATA = 2'd1,
      RESP      = 2'd2,
      DONE      = 2'd3
   } wr_state_t;

endpackage

// File: rtl/axi_lite_line_writer.sv
// Writes one captured cache line to memory as LINE_WORDS single-beat AXI4-Lite writes.
// Latency: 2 cycles per beat with an always-ready slave; done pulses 2*LINE_WORDS+1 cycles after start.
// Backpressure: AW and W each hold until their own ready; B is awaited for as long as the slave needs.
module axi_lite_line_writer
   import axi_lite_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int LINE_WORDS = 16
) (
   input  logic                             i_clk,
   input  logic                             i_arst,
   input  logic                             i_start,
   input  logic [ADDR_WIDTH-1:0]            i_base_addr,
   input  logic [LINE_WORDS*DATA_WIDTH-1:0] i_line_data,
   output logic                             o_busy,
   output logic                             o_done,
   output logic                             o_error,
   output logic [ADDR_WIDTH-1:0]            o_awaddr,
   output logic [2:0]                       o_awprot,
   output logic                             o_awvalid,
   input  logic                             i_awready,
   output logic [DATA_WIDTH-1:0]            o_wdata,
   output logic [DATA_WIDTH/8-1:0]          o_wstrb,
   output logic                             o_wvalid,
   input  logic                             i_wready,
   input  logic [1:0]                       i_bresp,
   input  logic                             i_bvalid,
   output logic                             o_bready
);

   localparam int BEAT_W = $clog2(LINE_WORDS);
   localparam int OFF_W  = $clog2(LINE_WORDS * DATA_WIDTH / 8);
   // Clears the byte offset within the line so the first beat lands on the line boundary
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'((64'd1 << OFF_W) - 64'd1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(DATA_WIDTH / 8);
   localparam logic [BEAT_W-1:0]     LAST_BEAT  = BEAT_W'(LINE_WORDS - 1);

   wr_state_t             state_q;
   wr_state_t             state_d;
   logic [BEAT_W-1:0]     beat_q;
   logic [BEAT_W-1:0]     beat_inc;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] line_q [LINE_WORDS];
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  awvalid_q;
   logic                  wvalid_q;
   logic                  aw_done_q;
   logic                  w_done_q;
   logic                  error_q;
   logic                  aw_hs;
   logic                  w_hs;
   logic                  b_hs;

   assign beat_inc = beat_q + 1'b1;

   // State register; reset abandons any line in flight
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and handshake decode; valids come from flops so no ready reaches a valid
   always_comb begin
      state_d  = state_q;
      aw_hs    = awvalid_q & i_awready;
      w_hs     = wvalid_q & i_wready;
      b_hs     = 1'b0;
      o_bready = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_start) begin
               state_d = ADDR_DATA;
            end
         end
         ADDR_DATA: begin
            // AW and W may complete on the same edge or on different edges in either order
            if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
               state_d = RESP;
            end
         end
         RESP: begin
            o_bready = 1'b1;
            b_hs     = i_bvalid;
            if (i_bvalid) begin
               state_d = (beat_q == LAST_BEAT) ? DONE : ADDR_DATA;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Line capture, beat advance, channel valids and sticky error
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         beat_q    <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         error_q   <= 1'b0;
         for (int k = 0; k < LINE_WORDS; k++) begin
            line_q[k] <= '0;
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (i_start) begin
                  for (int k = 0; k < LINE_WORDS; k++) begin
                     line_q[k] <= i_line_data[k*DATA_WIDTH +: DATA_WIDTH];
                  end
                  beat_q    <= '0;
                  addr_q    <= i_base_addr & ALIGN_MASK;
                  wdata_q   <= i_line_data[DATA_WIDTH-1:0];
                  error_q   <= 1'b0;
                  awvalid_q <= 1'b1;
                  wvalid_q  <= 1'b1;
                  aw_done_q <= 1'b0;
                  w_done_q  <= 1'b0;
               end
            end
            ADDR_DATA: begin
               if (aw_hs) begin
                  awvalid_q <= 1'b0;
                  aw_done_q <= 1'b1;
               end
               if (w_hs) begin
                  wvalid_q <= 1'b0;
                  w_done_q <= 1'b1;
               end
            end
            RESP: begin
               if (b_hs) begin
                  // Errors are recorded but never cut the line short
                  if (i_bresp != OKAY) begin
                     error_q <= 1'b1;
                  end
                  if (beat_q != LAST_BEAT) begin
                     beat_q    <= beat_inc;
                     addr_q    <= addr_q + ADDR_STEP;
                     wdata_q   <= line_q[beat_inc];
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     aw_done_q <= 1'b0;
                     w_done_q  <= 1'b0;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign o_busy    = (state_q != IDLE);
   assign o_done    = (state_q == DONE);
   assign o_error   = error_q;
   assign o_awaddr  = addr_q;
   assign o_awprot  = AXI_PROT;
   assign o_awvalid = awvalid_q;
   assign o_wdata   = wdata_q;
   assign o_wstrb   = '1;
   assign o_wvalid  = wvalid_q;

endmodule

// File: tb/tb_axi_lite_line_writer.sv
// Directed bench for the AXI4-Lite line writer with a cycle-level slave model.
// Latency: checks exact done cycle per scenario.
// Backpressure: slave inserts programmable AW/W/B delays.
module tb_axi_lite_line_writer;
   import axi_lite_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int LW = 16;

   logic             i_clk;
   logic             i_arst;
   logic             i_start;
   logic [AW-1:0]    i_base_addr;
   logic [LW*DW-1:0] i_line_data;
   logic             o_busy;
   logic             o_done;
   logic             o_error;
   logic [AW-1:0]    o_awaddr;
   logic [2:0]       o_awprot;
   logic             o_awvalid;
   logic             i_awready;
   logic [DW-1:0]    o_wdata;
   logic [DW/8-1:0]  o_wstrb;
   logic             o_wvalid;
   logic             i_wready;
   logic [1:0]       i_bresp;
   logic             i_bvalid;
   logic             o_bready;

   int n_chk  = 0;
   int n_fail = 0;

   axi_lite_line_writer #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .LINE_WORDS(LW)
   ) dut (
      .i_clk      (i_clk),
      .i_arst     (i_arst),
      .i_start    (i_start),
      .i_base_addr(i_base_addr),
      .i_line_data(i_line_data),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_error    (o_error),
      .o_awaddr   (o_awaddr),
      .o_awprot   (o_awprot),
      .o_awvalid  (o_awvalid),
      .i_awready  (i_awready),
      .o_wdata    (o_wdata),
      .o_wstrb    (o_wstrb),
      .o_wvalid   (o_wvalid),
      .i_wready   (i_wready),
      .i_bresp    (i_bresp),
      .i_bvalid   (i_bvalid),
      .o_bready   (o_bready)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [31:0] base;
      logic [31:0] seed;
      int          aw_dly;
      int          w_dly;
      bit          alt;
      int          b_dly;
      int          err_beat;
      int          repulse_beat;
      int          arst_beat;
      logic [31:0] exp_base;
      int          exp_done;
      bit          exp_err;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      i_start   = 1'b0;
      i_awready = 1'b0;
      i_wready  = 1'b0;
      i_bvalid  = 1'b0;
      i_bresp   = OKAY;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " busy"},    64'(o_busy),    64'd0);
      chk({tag, " done"},    64'(o_done),    64'd0);
      chk({tag, " error"},   64'(o_error),   64'd0);
      chk({tag, " awaddr"},  64'(o_awaddr),  64'd0);
      chk({tag, " awvalid"}, 64'(o_awvalid), 64'd0);
      chk({tag, " wdata"},   64'(o_wdata),   64'd0);
      chk({tag, " wvalid"},  64'(o_wvalid),  64'd0);
      chk({tag, " bready"},  64'(o_bready),  64'd0);
   endtask

   // Runs one line: start pulse, then a cycle-by-cycle slave that predicts every valid/ready
   task automatic run_line(input vec_t v);
      logic [LW*DW-1:0] ld;
      int  cyc, aw_cnt, w_cnt, b_cnt, aw_wait, w_wait, b_wait, dones, done_cyc;
      int  awd, wd;
      bit  aborted, repulsed, exp_awv, exp_wv, exp_br, exp_dn, rdy;
      for (int k = 0; k < LW; k++) ld[k*DW +: DW] = v.seed + 32'(k);
      cyc = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
      dones = 0; done_cyc = 0; aborted = 1'b0; repulsed = 1'b0;
      @(negedge i_clk);
      idle_inputs();
      i_base_addr = v.base;
      i_line_data = ld;
      i_start     = 1'b1;
      while (!aborted && cyc < 400 && !(dones > 0 && cyc >= done_cyc + 2)) begin
         @(negedge i_clk);
         cyc++;
         idle_inputs();
         i_line_data = ~ld;
         if (v.repulse_beat >= 0 && !repulsed && b_cnt == v.repulse_beat) begin
            i_start  = 1'b1;
            repulsed = 1'b1;
         end
         exp_awv = (aw_cnt == b_cnt) && (b_cnt < LW);
         exp_wv  = (w_cnt == b_cnt) && (b_cnt < LW);
         exp_br  = (aw_cnt == b_cnt + 1) && (w_cnt == b_cnt + 1);
         exp_dn  = (b_cnt == LW) && (dones == 0);
         chk("awvalid", 64'(o_awvalid), 64'(exp_awv));
         chk("wvalid",  64'(o_wvalid),  64'(exp_wv));
         chk("bready",  64'(o_bready),  64'(exp_br));
         chk("busy",    64'(o_busy),    64'(dones == 0));
         chk("done",    64'(o_done),    64'(exp_dn));
         if (cyc == 1) begin
            chk("error cleared on start", 64'(o_error), 64'd0);
            chk("awprot", 64'(o_awprot), 64'd0);
            chk("wstrb",  64'(o_wstrb),  64'hF);
         end
         if (o_done) begin
            dones++;
            done_cyc = cyc;
            chk("done cycle", 64'(cyc), 64'(v.exp_done));
            chk("error at done", 64'(o_error), 64'(v.exp_err));
         end
         if (v.arst_beat >= 0 && exp_br && b_cnt == v.arst_beat) begin
            i_arst = 1'b1;
            @(negedge i_clk);
            chk_all_zero("mid-line reset");
            i_arst  = 1'b0;
            aborted = 1'b1;
         end else begin
            awd = (v.alt && b_cnt[0]) ? v.w_dly : v.aw_dly;
            wd  = (v.alt && b_cnt[0]) ? v.aw_dly : v.w_dly;
            if (o_awvalid) begin
               rdy = (aw_wait >= awd);
               i_awready = rdy;
               if (rdy) begin
                  chk("awaddr", 64'(o_awaddr), 64'(v.exp_base + 32'(4 * aw_cnt)));
                  aw_cnt++;
                  aw_wait = 0;
               end else begin
                  aw_wait++;
               end
            end
            if (o_wvalid) begin
               rdy = (w_wait >= wd);
               i_wready = rdy;
               if (rdy) begin
                  chk("wdata", 64'(o_wdata), 64'(v.seed + 32'(w_cnt)));
                  w_cnt++;
                  w_wait = 0;
               end else begin
                  w_wait++;
               end
            end
            if (exp_br) begin
               if (b_wait >= v.b_dly) begin
                  i_bvalid = 1'b1;
                  i_bresp  = (b_cnt == v.err_beat) ? SLVERR : OKAY;
                  b_cnt++;
                  b_wait = 0;
               end else begin
                  b_wait++;
               end
            end
         end
      end
      idle_inputs();
      if (!aborted) begin
         chk("aw count",   64'(aw_cnt), 64'(LW));
         chk("w count",    64'(w_cnt),  64'(LW));
         chk("b count",    64'(b_cnt),  64'(LW));
         chk("done count", 64'(dones),  64'd1);
      end
   endtask

   vec_t vecs [5];
   vec_t hv;

   initial begin
      //           base          seed          awd wd alt bd err rp ar exp_base      done err
      vecs[0] = '{32'h0000_1040, 32'hA000_0000, 0, 0, 0, 0, -1, -1, -1, 32'h0000_1040, 33,  0};
      vecs[1] = '{32'h0000_1040, 32'hB000_0000, 3, 0, 1, 0, -1, -1, -1, 32'h0000_1040, 81,  0};
      vecs[2] = '{32'h0000_1040, 32'hC000_0000, 0, 0, 0, 5,  7, -1, -1, 32'h0000_1040, 113, 1};
      vecs[3] = '{32'hFFFF_FFC0, 32'hD000_0000, 0, 0, 0, 0, -1, -1, -1, 32'hFFFF_FFC0, 33,  0};
      vecs[4] = '{32'h0000_1047, 32'hE000_0000, 0, 0, 0, 0, -1, -1, -1, 32'h0000_1040, 33,  0};

      i_arst      = 1'b1;
      i_base_addr = '0;
      i_line_data = '0;
      idle_inputs();
      repeat (3) @(negedge i_clk);
      chk_all_zero("reset");
      i_arst = 1'b0;
      @(negedge i_clk);
      chk_all_zero("after reset");

      for (int i = 0; i < 5; i++) begin
         run_line(vecs[i]);
      end

      // Start re-pulsed during beat 4 with line data already changed: ignored
      hv = '{32'h0000_2000, 32'h5000_0000, 0, 0, 0, 0, -1, 4, -1, 32'h0000_2000, 33, 0};
      run_line(hv);

      // Error line, then reset during RESP of beat 9, then a clean line
      hv = '{32'h0000_3000, 32'h6000_0000, 0, 0, 0, 1, 2, -1, 9, 32'h0000_3000, 0, 0};
      run_line(hv);
      @(negedge i_clk);
      chk_all_zero("idle after reset");
      hv = '{32'h0000_4000, 32'h7000_0000, 0, 0, 0, 0, -1, -1, -1, 32'h0000_4000, 33, 0};
      run_line(hv);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
